// File: rtl/alu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package alu_pkg;

  localparam int unsigned MD_WIDTH = 64;
  localparam int unsigned MD_CNT_W = 7;
  localparam int unsigned TAG_W    = 5;

  // Operation encodings (Op input)
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the register-file read side and the mul/div unit.
interface mul_div_unit_if import alu_pkg::*; #(
  parameter int unsigned WIDTH = MD_WIDTH
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [TAG_W-1:0] RdIn;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [TAG_W-1:0] RdOut;

  modport master (
    output Start, Op, OpA, OpB, RdIn,
    input  Busy, Done, Result, RdOut
  );

  modport slave (
    input  Start, Op, OpA, OpB, RdIn,
    output Busy, Done, Result, RdOut
  );
endinterface

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module md_iter_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,    // product high half / partial remainder
  input  logic [WIDTH-1:0] lo_i,    // multiplier bits / dividend-then-quotient bits
  input  logic [WIDTH-1:0] opnd_i,  // multiplicand / divisor
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] shifted_c;
  logic [WIDTH:0] diff_c;

  // Select the multiply or divide step; remainder never exceeds WIDTH bits after restore
  always_comb begin
    sum_c     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted_c = {hi_i, lo_i[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, opnd_i};
    hi_o      = sum_c[WIDTH:1];
    lo_o      = {sum_c[0], lo_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!diff_c[WIDTH]) begin
        hi_o = diff_c[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted_c[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/UMULH/UDIV/SDIV unit: FSM, iteration counter and sign handling.
module mul_div_unit import alu_pkg::*; #(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input logic          Clk,
  input logic          ResetL,
  mul_div_unit_if.slave md
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] rd_pend_q, rd_pend_d;
  logic [TAG_W-1:0] rd_q, rd_d;

  logic             is_sdiv_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;

  // SDIV operands become magnitudes; other ops pass through unsigned
  assign is_sdiv_c = (md.Op == OP_SDIV);
  assign a_mag_c   = (is_sdiv_c && md.OpA[WIDTH-1]) ? -md.OpA : md.OpA;
  assign b_mag_c   = (is_sdiv_c && md.OpB[WIDTH-1]) ? -md.OpB : md.OpB;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q[1]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi_c),
    .lo_o     (step_lo_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_pend_d = rd_pend_q;
    rd_d      = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (md.Start) begin
          op_d      = md.Op;
          rd_pend_d = md.RdIn;
          hi_d      = '0;
          cnt_d     = '0;
          neg_d     = is_sdiv_c && (md.OpA[WIDTH-1] ^ md.OpB[WIDTH-1]);
          dz_d      = (md.OpB == '0);
          busy_d    = 1'b1;
          state_d   = ST_CALC;
          if (md.Op[1]) begin
            lo_d   = a_mag_c;
            opnd_d = b_mag_c;
          end else begin
            lo_d   = md.OpB;
            opnd_d = md.OpA;
          end
        end
      end
      ST_CALC: begin
        hi_d  = step_hi_c;
        lo_d  = step_lo_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        case (op_q)
          OP_MUL:   result_d = lo_q;
          OP_UMULH: result_d = hi_q;
          OP_UDIV:  result_d = dz_q ? '0 : lo_q;
          default:  result_d = dz_q ? '0 : (neg_q ? -lo_q : lo_q);
        endcase
        rd_d    = rd_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_pend_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_pend_q <= rd_pend_d;
      rd_q      <= rd_d;
    end
  end

  assign md.Busy   = busy_q;
  assign md.Done   = done_q;
  assign md.Result = result_q;
  assign md.RdOut  = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, decoupled Done monitor.
module tb_mul_div_unit;
  import alu_pkg::*;

  localparam int unsigned W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mul_div_unit_if #(.WIDTH(W)) md();

  mul_div_unit #(.WIDTH(W), .CNT_W(7)) dut (
    .Clk    (clk),
    .ResetL (rst_n),
    .md     (md.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every Done pulse pops one expected response
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && md.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual Result=0x%0h required no Done", md.Result);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk($sformatf("result_rd%0d", e.rd), md.Result, e.res);
        chk($sformatf("rdout_rd%0d", e.rd), 64'(md.RdOut), 64'(e.rd));
      end
    end
  end

  // Wait for idle, present a one-cycle Start, record the expected response
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic [W-1:0] exp_res);
    int guard = 0;
    while (md.Busy !== 1'b0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_wait_rd%0d actual=busy required=idle", rd);
    end
    md.Start = 1'b1;
    md.Op    = op;
    md.OpA   = a;
    md.OpB   = b;
    md.RdIn  = rd;
    exp_q.push_back('{exp_res, rd});
    n_push++;
    @(posedge clk); #1;
    md.Start = 1'b0;
    chk($sformatf("busy_after_accept_rd%0d", rd), 64'(md.Busy), 64'd1);
  endtask

  // Count edges until Done; also count cycles with Busy high
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    int bcnt;
    bcnt = (md.Busy === 1'b1) ? 1 : 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (md.Busy === 1'b1) bcnt++;
    end while (md.Done !== 1'b1 && lat < 200);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seen;
    md.Start = 1'b0;
    md.Op    = OP_MUL;
    md.OpA   = '0;
    md.OpB   = '0;
    md.RdIn  = '0;

    #2;
    chk("reset_busy",   64'(md.Busy),  64'd0);
    chk("reset_done",   64'(md.Done),  64'd0);
    chk("reset_result", md.Result,     64'd0);
    chk("reset_rdout",  64'(md.RdOut), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_MUL, 64'd7, 64'd6, 5'd5, 64'd42);
    wait_done("mul_7x6", 65);

    issue(OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done("umulh_max", 65);
    issue(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'd1);
    wait_done("mul_max", 65);

    issue(OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("sdiv_m7_2", 65);
    issue(OP_SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("sdiv_7_m2", 65);
    issue(OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'h8000_0000_0000_0000);
    wait_done("sdiv_ovf", 65);
    issue(OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFE, 5'd14, 64'd4);
    wait_done("sdiv_m8_m2", 65);

    issue(OP_UDIV, 64'd100, 64'd7, 5'd7, 64'd14);
    wait_done("udiv_100_7", 65);
    issue(OP_UDIV, 64'd5, 64'd0, 5'd8, 64'd0);
    wait_done("udiv_by0", 65);

    // Start pulsed mid-operation must be ignored
    issue(OP_MUL, 64'd7, 64'd6, 5'd9, 64'd42);
    repeat (10) @(posedge clk);
    #1;
    md.Start = 1'b1;
    md.Op    = OP_UDIV;
    md.OpA   = 64'd100;
    md.OpB   = 64'd7;
    md.RdIn  = 5'd10;
    @(posedge clk); #1;
    md.Start = 1'b0;
    wait_done("ignore_midop", 54);

    // Start held high: second op accepted on the edge that drops Done
    md.Start = 1'b1;
    md.Op    = OP_UDIV;
    md.OpA   = 64'd100;
    md.OpB   = 64'd7;
    md.RdIn  = 5'd11;
    exp_q.push_back('{64'd14, 5'd11});
    n_push++;
    @(posedge clk); #1;
    chk("hold_first_accept", 64'(md.Busy), 64'd1);
    md.Op   = OP_MUL;
    md.OpA  = 64'd3;
    md.OpB  = 64'd5;
    md.RdIn = 5'd12;
    exp_q.push_back('{64'd15, 5'd12});
    n_push++;
    wait_done("hold_first", 65);
    @(posedge clk); #1;
    chk("hold_second_busy", 64'(md.Busy), 64'd1);
    chk("hold_done_dropped", 64'(md.Done), 64'd0);
    md.Start = 1'b0;
    wait_done("hold_second", 65);

    // Reset mid-operation aborts without Done
    issue(OP_MUL, 64'hDEAD, 64'hBEEF, 5'd20, 64'd0);
    void'(exp_q.pop_back());
    n_push--;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   64'(md.Busy),  64'd0);
    chk("abort_done",   64'(md.Done),  64'd0);
    chk("abort_result", md.Result,     64'd0);
    chk("abort_rdout",  64'(md.RdOut), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (md.Done === 1'b1) seen++;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);

    issue(OP_MUL, 64'd3, 64'd3, 5'd13, 64'd9);
    wait_done("mul_after_reset", 65);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("responses_seen", 64'(n_pop), 64'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide execution unit that sits directly downstream of the register file.
- Consumes the two register-file read buses as operands and produces one 64-bit result plus a destination tag.
- The result is later driven onto the register-file write bus.
- Covers the LEGv8 MUL, UMULH, UDIV and SDIV instructions, using one radix-2 iteration per clock.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CNT_W, 7, iteration-counter width; must hold WIDTH.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- ResetL  input  1  asynchronous reset, active-low.
- Start  input  1  request strobe; sampled only when Busy=0.
- Op  input  2  operation: 00 MUL, 01 UMULH, 10 UDIV, 11 SDIV.
- OpA  input  WIDTH  operand A (register-file BusA); dividend / multiplicand.
- OpB  input  WIDTH  operand B (register-file BusB); divisor / multiplier.
- RdIn  input  5  destination register tag.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse; Result and RdOut valid in that cycle.
- Result  output  WIDTH  operation result.
- RdOut  output  5  tag captured with the accepted request.

Behaviour:
- Reset (ResetL=0, asynchronous):
  - State=IDLE; Busy=0, Done=0, Result=0, RdOut=0, counter=0.
  - Asserting reset mid-operation aborts the operation; no Done is produced.
- States: IDLE, CALC, FINISH.
- IDLE:
  - Start=1 at a rising edge accepts the request: latch Op, RdIn and the working operands; counter=0; go to CALC; Busy=1 from that edge.
  - Start=0: stay in IDLE.
- Start while Busy=1 is ignored; there is no queuing. Operands are sampled only at the accepting edge.
- Operand preparation at accept:
  - SDIV converts both operands to magnitudes; quotient sign = sign(A) XOR sign(B).
  - MUL and UMULH are unsigned.
- CALC: one iteration per edge, exactly WIDTH iterations; after iteration WIDTH-1 go to FINISH.
  - Multiply: shift-add into a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract with a WIDTH+1-bit partial remainder.
- FINISH (one cycle):
  - MUL: Result = product[WIDTH-1:0].
  - UMULH: Result = product[2*WIDTH-1:WIDTH].
  - UDIV: Result = unsigned quotient.
  - SDIV: Result = two's complement negation of the quotient if the sign bit is set, otherwise the quotient; truncates toward zero.
  - Done=1; go to IDLE; Busy=0 from that same edge.
- Latency: accepting edge k -> Done high in the cycle after edge k+WIDTH+1 (edge k+65 at default). Busy is high for WIDTH+1 cycles.
- Back-to-back issue: a new Start is accepted on the first edge where Busy=0, which is the same edge that drops Done.
- Divide by zero (OpB=0, UDIV/SDIV): Result=0, same latency, no exception.
- SDIV overflow (A=0x8000_0000_0000_0000, B=-1): Result=0x8000_0000_0000_0000, i.e. the natural wrap.
- Result and RdOut hold their last values until the next FINISH; only Done qualifies them.
- Fully synchronous except reset; no combinational path from inputs to outputs.

Decomposition:
- Shared package (alu_pkg):
  - Op encodings OP_MUL, OP_UMULH, OP_UDIV, OP_SDIV.
  - State enum values.
  - WIDTH default.
- One natural sub-module: md_iter_step, the combinational single-iteration datapath. It selects the add-shift or subtract-shift step from the op class.
- The FSM, counter and sign handling stay in the top module.

Test Plan:
- MUL: OpA=7, OpB=6, RdIn=5 -> Done 65 cycles after accept; Result=42, RdOut=5. Busy high for exactly 65 cycles.
- UMULH: OpA=OpB=0xFFFF_FFFF_FFFF_FFFF -> Result=0xFFFF_FFFF_FFFF_FFFE. Same operands with MUL -> Result=1.
- SDIV:
  - -7/2 -> Result=-3 (0xFFFF_FFFF_FFFF_FFFD).
  - 7/-2 -> -3.
  - 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
- UDIV: 100/7 -> 14. 5/0 -> 0, with normal latency and Done.
- Start pulsed mid-operation with different operands -> ignored, first result unchanged. Start held high through Done -> second op accepted on the edge where Done drops.
- ResetL dropped for 1 cycle at iteration 30 -> Busy=0, Done=0, Result=0 immediately, no Done pulse afterward. A fresh MUL 3*3 then returns 9.
